// File: rtl/int_arbiter.sv
// int_arbiter: captures source request edges into pending bits, arbitrates among enabled ones and runs the CPU claim/complete handshake.
// Define INT_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority with index 0 highest.
module int_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic [NUM_SRC-1:0] src_ack,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               glb_en,
    output logic               cpu_irq,
    output logic [ID_W-1:0]    cpu_irq_id,
    input  logic               cpu_claim,
    input  logic               cpu_complete,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t             r_state;
    logic [NUM_SRC-1:0] r_src_d;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_sel;
    logic [NUM_SRC-1:0] w_clr;
    logic [ID_W-1:0]    w_win;
    logic               w_claim;

    assign w_elig  = pending & irq_en & {NUM_SRC{glb_en}};
    assign w_claim = (r_state == REQ) && cpu_claim;
    assign w_sel   = NUM_SRC'(1) << cpu_irq_id;
    assign w_clr   = w_claim ? w_sel : '0;

`ifdef INT_ARBITER_RR_EN
    logic [ID_W-1:0] r_last;
    logic            w_found;

    // Search starts just past the last claimed source and wraps.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            if (!w_found && w_elig[(int'(r_last) + 1 + k) % NUM_SRC]) begin
                w_win   = ID_W'((int'(r_last) + 1 + k) % NUM_SRC);
                w_found = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            r_last <= ID_W'(NUM_SRC - 1);
        else if (w_claim)
            r_last <= cpu_irq_id;
`else
    always_comb begin
        w_win = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (w_elig[k])
                w_win = ID_W'(k);
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_src_d    <= '0;
            pending    <= '0;
            src_ack    <= '0;
            cpu_irq    <= 1'b0;
            cpu_irq_id <= '0;
            busy       <= 1'b0;
        end else begin
            r_src_d <= src_irq;
            // A new edge outranks a same-cycle claim clear on the same bit.
            pending <= (pending & ~w_clr) | (src_irq & ~r_src_d);
            src_ack <= '0;
            case (r_state)
                IDLE:
                    if (|w_elig) begin
                        cpu_irq_id <= w_win;
                        cpu_irq    <= 1'b1;
                        r_state    <= REQ;
                    end
                REQ:
                    if (cpu_claim) begin
                        src_ack <= w_sel;
                        cpu_irq <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= SERVICE;
                    end else if (!w_elig[cpu_irq_id]) begin
                        cpu_irq <= 1'b0;
                        r_state <= IDLE;
                    end
                SERVICE:
                    if (cpu_complete) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
